hex_display_scheduler: RTL and testbench

// Shares the six-digit 7-segment bank (HEX5..HEX0) between two requesters, A and B.

---
 rtl/hex_display_scheduler.sv | 122 ++++++++++++
 tb/tb_hex_display_scheduler.sv | 125 ++++++++++++
 2 files changed

// File: rtl/hex_display_scheduler.sv
// Round-robin arbiter sharing a six-digit 7-segment bank between requesters A and B.
// Latency: grant and glyphs register one cycle after the request; the winner keeps the bank HOLD_CYCLES cycles under contention.
module hex_display_scheduler #(
  parameter int HOLD_CYCLES = 50000000
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        req_a,
  input  logic [23:0] data_a,
  input  logic        req_b,
  input  logic [23:0] data_b,
  output logic        grant_a,
  output logic        grant_b,
  output logic [6:0]  HEX0,
  output logic [6:0]  HEX1,
  output logic [6:0]  HEX2,
  output logic [6:0]  HEX3,
  output logic [6:0]  HEX4,
  output logic [6:0]  HEX5
);

  localparam int CW = $clog2(HOLD_CYCLES + 1);
  localparam logic [CW-1:0] CNT_MAX = CW'(HOLD_CYCLES - 1);
  localparam logic [6:0] BLANK = 7'h7F;

  typedef enum logic [1:0] {IDLE, SHOW_A, SHOW_B} state_t;

  state_t        state, nxt;
  logic [CW-1:0] cnt;
  logic          last_a;
  logic [23:0]   sel_dat;

  function automatic logic [6:0] glyph(input logic [3:0] n);
    case (n)
      4'h0: glyph = 7'h40;
      4'h1: glyph = 7'h79;
      4'h2: glyph = 7'h24;
      4'h3: glyph = 7'h30;
      4'h4: glyph = 7'h19;
      4'h5: glyph = 7'h12;
      4'h6: glyph = 7'h02;
      4'h7: glyph = 7'h78;
      4'h8: glyph = 7'h00;
      4'h9: glyph = 7'h10;
      4'hA: glyph = 7'h08;
      4'hB: glyph = 7'h03;
      4'hC: glyph = 7'h46;
      4'hD: glyph = 7'h21;
      4'hE: glyph = 7'h06;
      default: glyph = 7'h0E;
    endcase
  endfunction

  always_comb begin
    nxt = state;
    case (state)
      IDLE: begin
        if (req_a && req_b) nxt = last_a ? SHOW_B : SHOW_A;
        else if (req_a)     nxt = SHOW_A;
        else if (req_b)     nxt = SHOW_B;
      end
      SHOW_A: begin
        if (!req_a)               nxt = req_b ? SHOW_B : IDLE;
        else if (req_b && cnt == CNT_MAX) nxt = SHOW_B;
      end
      SHOW_B: begin
        if (!req_b)               nxt = req_a ? SHOW_A : IDLE;
        else if (req_a && cnt == CNT_MAX) nxt = SHOW_A;
      end
      default: nxt = IDLE;
    endcase
  end

  // Only the next owner's data is routed, so the other side's value never reaches the glyphs.
  always_comb begin
    sel_dat = 24'h0;
    if (nxt == SHOW_A)      sel_dat = data_a;
    else if (nxt == SHOW_B) sel_dat = data_b;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state   <= IDLE;
      cnt     <= '0;
      last_a  <= 1'b0;
      grant_a <= 1'b0;
      grant_b <= 1'b0;
      HEX0    <= BLANK;
      HEX1    <= BLANK;
      HEX2    <= BLANK;
      HEX3    <= BLANK;
      HEX4    <= BLANK;
      HEX5    <= BLANK;
    end else begin
      state   <= nxt;
      grant_a <= (nxt == SHOW_A);
      grant_b <= (nxt == SHOW_B);
      if (nxt != state)
        cnt <= '0;
      else if (state != IDLE && cnt != CNT_MAX)
        cnt <= cnt + 1'b1;
      if (nxt != state && nxt == SHOW_A) last_a <= 1'b1;
      if (nxt != state && nxt == SHOW_B) last_a <= 1'b0;
      if (nxt == IDLE) begin
        HEX0 <= BLANK;
        HEX1 <= BLANK;
        HEX2 <= BLANK;
        HEX3 <= BLANK;
        HEX4 <= BLANK;
        HEX5 <= BLANK;
      end else begin
        HEX0 <= glyph(sel_dat[3:0]);
        HEX1 <= glyph(sel_dat[7:4]);
        HEX2 <= glyph(sel_dat[11:8]);
        HEX3 <= glyph(sel_dat[15:12]);
        HEX4 <= glyph(sel_dat[19:16]);
        HEX5 <= glyph(sel_dat[23:20]);
      end
    end
  end

endmodule

// File: tb/tb_hex_display_scheduler.sv
// Directed bench for hex_display_scheduler with a 4-cycle hold.
module tb_hex_display_scheduler;

  logic        clock = 1'b0;
  logic        reset;
  logic        req_a, req_b;
  logic [23:0] data_a, data_b;
  logic        grant_a, grant_b;
  logic [6:0]  HEX0, HEX1, HEX2, HEX3, HEX4, HEX5;

  int checks = 0;
  int errors = 0;

  hex_display_scheduler #(.HOLD_CYCLES(4)) dut (
    .clock(clock), .reset(reset),
    .req_a(req_a), .data_a(data_a),
    .req_b(req_b), .data_b(data_b),
    .grant_a(grant_a), .grant_b(grant_b),
    .HEX0(HEX0), .HEX1(HEX1), .HEX2(HEX2),
    .HEX3(HEX3), .HEX4(HEX4), .HEX5(HEX5)
  );

  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [47:0] obs, input logic [47:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  function automatic logic [47:0] hexes(input logic [6:0] h5, h4, h3, h2, h1, h0);
    return {6'b0, h5, h4, h3, h2, h1, h0};
  endfunction

  logic [47:0] hex_now;
  assign hex_now = {6'b0, HEX5, HEX4, HEX3, HEX2, HEX1, HEX0};

  localparam logic [47:0] ALL_BLANK = {6'b0, {6{7'h7F}}};
  // 012345 -> HEX5..HEX0 = 0,1,2,3,4,5
  localparam logic [47:0] HEX_012345 = {6'b0, 7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12};
  // ABCDEF -> HEX5..HEX0 = A,b,C,d,E,F
  localparam logic [47:0] HEX_ABCDEF = {6'b0, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};

  initial begin
    reset = 1'b1; req_a = 1'b1; req_b = 1'b1;
    data_a = 24'h012345; data_b = 24'hABCDEF;

    // 1: reset held with both requesting
    tick(); tick();
    check("reset_grants", {46'b0, grant_a, grant_b}, 48'd0);
    check("reset_hex", hex_now, ALL_BLANK);

    // 2: single request from A
    reset = 1'b0; req_b = 1'b0;
    tick();
    check("a_only_grants", {46'b0, grant_a, grant_b}, 48'd2);
    check("a_only_hex", hex_now, HEX_012345);
    check("a_only_hex0", {41'b0, HEX0}, 48'h12);

    // 3: contention from IDLE, hold of 4
    reset = 1'b1; req_a = 1'b1; req_b = 1'b1;
    tick(); tick();
    reset = 1'b0;
    for (int i = 0; i < 12; i++) begin
      tick();
      if (i < 4 || i >= 8) begin
        check($sformatf("rr_grant_a_%0d", i), {46'b0, grant_a, grant_b}, 48'd2);
        check($sformatf("rr_hex_a_%0d", i), hex_now, HEX_012345);
      end else begin
        check($sformatf("rr_grant_b_%0d", i), {46'b0, grant_a, grant_b}, 48'd1);
        check($sformatf("rr_hex_b_%0d", i), hex_now, HEX_ABCDEF);
      end
    end

    // 4: A owns with count 1, B arrives and A drops
    reset = 1'b1; req_b = 1'b0; req_a = 1'b1;
    tick();
    reset = 1'b0;
    tick();
    tick();
    check("hold_a_grants", {46'b0, grant_a, grant_b}, 48'd2);
    req_a = 1'b0; req_b = 1'b1;
    tick();
    check("switch_b_grants", {46'b0, grant_a, grant_b}, 48'd1);
    check("switch_b_hex", hex_now, HEX_ABCDEF);

    // 5: owner data change, non-owner data undefined, then release
    data_b = 24'h000008; data_a = 'x;
    tick();
    check("live_b_hex", hex_now, hexes(7'h40, 7'h40, 7'h40, 7'h40, 7'h40, 7'h00));
    check("live_b_grants", {46'b0, grant_a, grant_b}, 48'd1);
    req_b = 1'b0;
    tick();
    check("idle_grants", {46'b0, grant_a, grant_b}, 48'd0);
    check("idle_hex", hex_now, ALL_BLANK);

    // 6: reset during B contention, then A wins first
    data_a = 24'h012345; data_b = 24'hABCDEF;
    req_b = 1'b1;
    tick();
    check("b_only_grants", {46'b0, grant_a, grant_b}, 48'd1);
    req_a = 1'b1;
    tick();
    check("b_held_grants", {46'b0, grant_a, grant_b}, 48'd1);
    reset = 1'b1;
    tick();
    check("mid_reset_grants", {46'b0, grant_a, grant_b}, 48'd0);
    check("mid_reset_hex", hex_now, ALL_BLANK);
    reset = 1'b0;
    tick();
    check("post_reset_grants", {46'b0, grant_a, grant_b}, 48'd2);
    check("post_reset_hex", hex_now, HEX_012345);

    $display("End of test - %0d assertions evaluated, %0d failures", checks, errors);
    $finish;
  end

endmodule
